// File: rtl/calc2_pkg.sv
// CALC2 responder shared types: commands, response codes, queued request.
// Shift commands are only executable when CALC2_RESP_SHIFT_EN is defined.
package calc2_pkg;

  localparam int DW = 32;
  localparam int TW = 2;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef struct packed {
    logic [3:0]    cmd;
    logic [TW-1:0] tag;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
  } req_entry_t;

endpackage

// File: rtl/calc2_req_fifo.sv
// In-order request queue; a push while full is ignored even if a pop
// happens in the same cycle (the caller flags it as a protocol error).
module calc2_req_fifo
  import calc2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  req_entry_t din_i,
  input  logic       pop_i,
  output req_entry_t dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  req_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rp_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/calc2_port_responder.sv
// CALC2 single-port responder: two-cycle request capture, queue, executor.
// Define CALC2_RESP_SHIFT_EN to execute shl/shr; otherwise they are invalid.
module calc2_port_responder
  import calc2_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  input  logic [1:0]  req_tag_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic        proto_err
);

  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic {ST_IDLE, ST_OP2} cap_e;

  cap_e          st_q;
  logic [3:0]    cmd_q;
  logic [TW-1:0] tag_q;
  logic [DW-1:0] op1_q;
  logic          perr_q;

  req_entry_t push_d;
  req_entry_t head;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;

  assign push   = (st_q == ST_OP2);
  assign push_d = '{cmd: cmd_q, tag: tag_q,
                    op1: op1_q, op2: req_data_in};

  always_ff @(posedge c_clk) begin
    if (reset) begin
      st_q   <= ST_IDLE;
      cmd_q  <= '0;
      tag_q  <= '0;
      op1_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (req_cmd_in != CMD_NOP) begin
            cmd_q <= req_cmd_in;
            tag_q <= req_tag_in;
            op1_q <= req_data_in;
            st_q  <= ST_OP2;
          end
        end
        ST_OP2: begin
          st_q <= ST_IDLE;
          if (req_cmd_in != CMD_NOP || full) perr_q <= 1'b1;
        end
      endcase
    end
  end

  calc2_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (c_clk),
    .rst_i   (reset),
    .push_i  (push),
    .din_i   (push_d),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Busy covers the cycles between pop and the response cycle, so the
  // executor can pop again in the very cycle its response is visible.
  req_entry_t    ex_q;
  req_entry_t    src;
  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic          fire;

  assign pop  = !busy_q && !empty;
  assign src  = (LATENCY == 1) ? head : ex_q;
  assign fire = (LATENCY == 1) ? pop
                               : (busy_q && cnt_q == CW'(1));

  always_ff @(posedge c_clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      ex_q   <= '0;
    end else if (pop && LATENCY > 1) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(LATENCY - 1);
      ex_q   <= head;
    end else if (busy_q) begin
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  resp_e         res_resp;
  logic [DW-1:0] res_data;
  logic [DW:0]   sum;

  always_comb begin
    res_resp = RESP_ERR;
    res_data = '0;
    sum      = {1'b0, src.op1} + {1'b0, src.op2};
    case (src.cmd)
      CMD_ADD: begin
        if (!sum[DW]) begin
          res_resp = RESP_OK;
          res_data = sum[DW-1:0];
        end
      end
      CMD_SUB: begin
        if (src.op2 <= src.op1) begin
          res_resp = RESP_OK;
          res_data = src.op1 - src.op2;
        end
      end
`ifdef CALC2_RESP_SHIFT_EN
      CMD_SHL: begin
        res_resp = RESP_OK;
        res_data = src.op1 << src.op2[4:0];
      end
      CMD_SHR: begin
        res_resp = RESP_OK;
        res_data = src.op1 >> src.op2[4:0];
      end
`endif
      default: ;
    endcase
  end

  resp_e         resp_q;
  logic [DW-1:0] data_q;
  logic [TW-1:0] otag_q;

  always_ff @(posedge c_clk) begin
    if (reset || !fire) begin
      resp_q <= RESP_NONE;
      data_q <= '0;
      otag_q <= '0;
    end else begin
      resp_q <= res_resp;
      data_q <= res_data;
      otag_q <= src.tag;
    end
  end

  assign out_resp  = resp_q;
  assign out_data  = data_q;
  assign out_tag   = otag_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_calc2_port_responder.sv
// Scoreboard bench for calc2_port_responder: stimulus queues expected
// responses with their due cycle; a negedge monitor pops and compares.
module tb_calc2_port_responder;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_cmd_in = '0;
  logic [31:0] req_data_in = '0;
  logic [1:0]  req_tag_in = '0;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        proto_err;

  calc2_port_responder dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .req_tag_in  (req_tag_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .proto_err   (proto_err)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic perr_chk = 1'b0;
  logic perr_exp = 1'b0;
  logic final_chk = 1'b0;
  logic final_done = 1'b0;

  always @(posedge c_clk) cyc <= cyc + 1;

  always @(negedge c_clk) begin
    exp_t e;
    if (out_resp != 2'd0) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp cyc=%0d got resp=%0d data=%h tag=%0d, want none",
                 cyc, out_resp, out_data, out_tag);
      end else begin
        e = sb.pop_front();
        if (out_resp !== e.resp || out_data !== e.data ||
            out_tag !== e.tag || cyc != e.cyc) begin
          fails++;
          $display("FAIL resp_chk got resp=%0d data=%h tag=%0d cyc=%0d, want resp=%0d data=%h tag=%0d cyc=%0d",
                   out_resp, out_data, out_tag, cyc,
                   e.resp, e.data, e.tag, e.cyc);
        end
      end
    end else if (cyc > 0) begin
      checks++;
      if (out_data !== 32'd0 || out_tag !== 2'd0) begin
        fails++;
        $display("FAIL idle_zero cyc=%0d got data=%h tag=%0d, want 0",
                 cyc, out_data, out_tag);
      end
    end
    if (perr_chk) begin
      checks++;
      if (proto_err !== perr_exp) begin
        fails++;
        $display("FAIL proto_err cyc=%0d got %b, want %b",
                 cyc, proto_err, perr_exp);
      end
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        fails++;
        $display("FAIL missing_resp got %0d outstanding, want 0", sb.size());
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge c_clk); #1;
      req_cmd_in  = '0;
      req_tag_in  = '0;
      req_data_in = '0;
    end
  endtask

  task automatic send(input logic [3:0] c, input logic [1:0] t,
                      input logic [31:0] a, input logic [31:0] b,
                      output int n);
    @(posedge c_clk); #1;
    req_cmd_in  = c;
    req_tag_in  = t;
    req_data_in = a;
    n = cyc;
    @(posedge c_clk); #1;
    req_cmd_in  = '0;
    req_tag_in  = '0;
    req_data_in = b;
  endtask

  task automatic expect_rsp(input logic [1:0] r, input logic [31:0] d,
                            input logic [1:0] t, input int at);
    exp_t e;
    e.resp = r;
    e.data = d;
    e.tag  = t;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic one(input logic [3:0] c, input logic [1:0] t,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] r, input logic [31:0] d);
    int n;
    send(c, t, a, b, n);
    expect_rsp(r, d, t, n + 5);
    idle(10);
  endtask

  initial begin
    int n;
    int base;
    reset = 1'b1;
    idle(2);
    perr_exp = 1'b0;
    perr_chk = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(3);

    one(4'd1, 2'd2, 32'h0000_0005, 32'h0000_0007, 2'd1, 32'h0000_000C);
    one(4'd1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
    one(4'd2, 2'd3, 32'h0000_0003, 32'h0000_0004, 2'd2, 32'h0);
    one(4'd2, 2'd0, 32'h0000_0009, 32'h0000_0004, 2'd1, 32'h0000_0005);
    one(4'd1, 2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF);
`ifdef CALC2_RESP_SHIFT_EN
    one(4'd5, 2'd1, 32'h0000_0001, 32'h0000_0023, 2'd1, 32'h0000_0008);
    one(4'd6, 2'd2, 32'h8000_0000, 32'd31, 2'd1, 32'h0000_0001);
`else
    one(4'd5, 2'd1, 32'h0000_0001, 32'h0000_0023, 2'd2, 32'h0);
    one(4'd6, 2'd2, 32'h8000_0000, 32'd31, 2'd2, 32'h0);
`endif
    one(4'd4, 2'd0, 32'h0000_1234, 32'h0000_5678, 2'd2, 32'h0);
    one(4'd15, 2'd3, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0);

    // command during the operand2 cycle: ignored, first request still runs
    perr_chk = 1'b0;
    @(posedge c_clk); #1;
    req_cmd_in = 4'd1; req_tag_in = 2'd1; req_data_in = 32'd10;
    n = cyc;
    @(posedge c_clk); #1;
    req_cmd_in = 4'd2; req_tag_in = 2'd3; req_data_in = 32'd20;
    expect_rsp(2'd1, 32'd30, 2'd1, n + 5);
    idle(2);
    perr_exp = 1'b1;
    perr_chk = 1'b1;
    idle(10);

    // reset before the first response discards everything in flight
    send(4'd1, 2'd0, 32'd1, 32'd2, n);
    send(4'd1, 2'd1, 32'd3, 32'd4, n);
    perr_chk = 1'b0;
    @(posedge c_clk); #1;
    reset = 1'b1;
    req_cmd_in = '0; req_data_in = '0;
    @(posedge c_clk); #1;
    reset = 1'b0;
    perr_exp = 1'b0;
    perr_chk = 1'b1;
    idle(12);
    one(4'd1, 2'd3, 32'd1, 32'd1, 2'd1, 32'd2);

    // back-to-back stream; queue is full at request 11 which is dropped
    for (int k = 0; k < 12; k++) begin
      if (k == 11) perr_chk = 1'b0;
      send(4'd1, 2'(k), 32'(k), 32'h10, n);
      if (k == 0) base = n;
      if (k != 11) expect_rsp(2'd1, 32'(k + 16), 2'(k), base + 5 + 3 * k);
    end
    idle(2);
    perr_exp = 1'b1;
    perr_chk = 1'b1;
    idle(25);

    final_chk = 1'b1;
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
